gru_update_seq: RTL and testbench
=================================

GRU_UPDATE_SEQ -- requirements
Module: gru_update_seq

Interface
REQ-001 Parameter DATABIT, default 16, sample width in bits (signed two's complement).
REQ-002 Parameter FRAC, default 14, fractional bits (Q2.14); 1.0 = 16'h4000.
REQ-003 Parameter HIDDEN_N, default 32, number of hidden units per sweep (2..1024).
REQ-004 Parameter ADDR_W, default $clog2(HIDDEN_N), address width.
REQ-005 clk  in  1  single clock; all state updates on the rising edge.
REQ-006 rst_n  in  1  asynchronous, active-low reset.
REQ-007 start  in  1  single-cycle request to begin one sweep.
REQ-008 hold  in  1  while high, no new element is issued.
REQ-009 busy  out  1  high from sweep acceptance until done.
REQ-010 done  out  1  one-cycle pulse at sweep completion.
REQ-011 rd_en  out  1  read strobe to the zt/ht1/htb buffers.
REQ-012 rd_addr  out  ADDR_W  element index being read.
REQ-013 zt_in, ht1_in, htb_in  in  DATABIT each  buffer data, valid exactly 1 cycle after rd_en.
REQ-014 wr_en  out  1  write strobe for the result buffer.
REQ-015 wr_addr  out  ADDR_W  element index of ht_out.
REQ-016 ht_out  out  DATABIT  updated hidden value.

Function
REQ-017 The block SHALL compute ht = zt*ht1 + (1.0 - zt)*htb per element, where 1.0 = 16'h4000.
REQ-018 Products SHALL be full 2*DATABIT signed, arithmetically shifted right by FRAC; the sum SHALL be formed in DATABIT+2 bits before final width reduction.
REQ-019 FSM states SHALL be IDLE, RUN, DRAIN, DONE.
REQ-020 IDLE->RUN on start; start in any other state SHALL be ignored.
REQ-021 In RUN, one element SHALL be issued per cycle with hold low (rd_en=1, rd_addr incrementing from 0); with hold high, rd_en=0 and rd_addr holds.
REQ-022 RUN->DRAIN in the cycle after rd_addr=HIDDEN_N-1 is issued; rd_addr SHALL NOT wrap.
REQ-023 Element latency SHALL be fixed: wr_en for an element asserts exactly 4 cycles after its rd_en (1 read + 3 arithmetic stages); in-flight elements SHALL drain regardless of hold.
REQ-024 wr_addr SHALL equal the rd_addr of the same element; writes occur in address order with no gaps or duplicates.
REQ-025 DRAIN->DONE in the cycle after the last wr_en; DONE asserts done for 1 cycle, then returns to IDLE.
REQ-026 With hold never asserted, a sweep SHALL take HIDDEN_N+5 cycles from start to done.
REQ-027 A start coincident with done SHALL be ignored; a new start is accepted from IDLE only.

Reset
REQ-028 On rst_n low: state=IDLE; busy, done, rd_en, wr_en = 0; rd_addr, wr_addr, ht_out = 0; pipeline valid bits cleared.
REQ-029 Reset mid-sweep SHALL abort it: no further wr_en and no done pulse for that sweep.

Configuration
REQ-030 Macro GRU_UPDATE_SAT_EN defined: the DATABIT+2 sum SHALL saturate to [16'h8000, 16'h7FFF].
REQ-031 Macro GRU_UPDATE_SAT_EN undefined: the sum SHALL be truncated to the low DATABIT bits (wrap-around).

Structure
REQ-032 DATABIT, FRAC, the 1.0 constant (ONE_Q) and the FSM state enum SHALL live in shared package gru_pkg.
REQ-033 The 3-stage arithmetic SHALL be a single sub-module gru_update_dp (inputs zt, ht1, htb, valid; outputs ht, valid); the FSM, counters and valid tracking stay in gru_update_seq.

Verification
REQ-034 zt=16'h4000, ht1=16'h2000, htb=16'h1000 for all elements -> every ht_out=16'h2000.
REQ-035 zt=16'h2000, ht1=16'h4000, htb=16'h0000 -> ht_out=16'h2000.
REQ-036 zt=16'h7FFF, ht1=16'h7FFF, htb=16'h8000 -> ht_out=16'h7FFF with GRU_UPDATE_SAT_EN, 16'h7FFA without.
REQ-037 HIDDEN_N=32, no hold -> done exactly 37 cycles after start, 32 writes with addresses 0..31; start pulsed mid-sweep -> ignored.
REQ-038 hold high for 3 cycles at element 10 -> rd_en low for those 3 cycles, elements 7..9 still written, final write order 0..31 intact, done delayed by 3 cycles.
REQ-039 rst_n low at element 15 -> all outputs 0 within the same cycle, no done; a subsequent start -> full clean sweep.

Source files
------------

// File: rtl/gru_pkg.sv
//------------------------------------------------------------------------------
// gru_pkg
// Shared widths, fixed-point constants and sweep FSM states for the GRU
// hidden-state update block.
// Rev 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package gru_pkg;

    // Default sample format: signed Q2.14
    localparam int DATABIT = 16;
    localparam int FRAC    = 14;

    // Fixed-point 1.0 in the default format
    localparam logic [DATABIT-1:0] ONE_Q = DATABIT'(1) << FRAC;

    // Sweep sequencer states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } gru_state_e;

endpackage : gru_pkg

`default_nettype wire

// File: rtl/gru_update_dp.sv
//------------------------------------------------------------------------------
// gru_update_dp
// Three-stage arithmetic pipe computing ht = zt*ht1 + (1.0 - zt)*htb.
//   stage 1: full-width products
//   stage 2: arithmetic shift by FRAC and sum in DATABIT+2 bits
//   stage 3: reduction to DATABIT bits (registered result)
// Build option: GRU_UPDATE_SAT_EN -- saturate the reduction instead of wrapping.
// Rev 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module gru_update_dp
    import gru_pkg::*;
#(
    parameter int DATABIT = gru_pkg::DATABIT,
    parameter int FRAC    = gru_pkg::FRAC
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic signed [DATABIT-1:0] zt_i,
    input  logic signed [DATABIT-1:0] ht1_i,
    input  logic signed [DATABIT-1:0] htb_i,
    input  logic                      valid_i,
    output logic signed [DATABIT-1:0] ht_o,
    output logic                      valid_o
);

    // Products are one bit wider than 2*DATABIT because (1.0 - zt) needs
    // DATABIT+1 bits when zt is the most negative code.
    localparam int PW = 2 * DATABIT + 1;
    localparam int SW = DATABIT + 2;

    localparam logic signed [DATABIT:0] ONE_X   = (DATABIT + 1)'(1) << FRAC;
    localparam logic signed [SW-1:0]    SAT_MAX = SW'(2 ** (DATABIT - 1) - 1);
    localparam logic signed [SW-1:0]    SAT_MIN = -SAT_MAX - SW'(1);

    logic signed [DATABIT:0]   omz;
    logic signed [PW-1:0]      p1_q, p2_q;
    logic signed [SW-1:0]      sum_d, sum_q;
    logic signed [DATABIT-1:0] red_d, ht_q;
    logic                      v1_q, v2_q, v3_q;

    // Shift both products and add them in the DATABIT+2 accumulator width
    always_comb begin
        omz   = ONE_X - {zt_i[DATABIT-1], zt_i};
        sum_d = SW'(p1_q >>> FRAC) + SW'(p2_q >>> FRAC);
    end

    // Reduce the accumulator to the output width
    always_comb begin
        red_d = sum_q[DATABIT-1:0];
`ifdef GRU_UPDATE_SAT_EN
        if (sum_q > SAT_MAX) begin
            red_d = SAT_MAX[DATABIT-1:0];
        end else if (sum_q < SAT_MIN) begin
            red_d = SAT_MIN[DATABIT-1:0];
        end
`endif
    end

    // Pipeline registers with valid tracking; valids clear on reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p1_q  <= '0;
            p2_q  <= '0;
            sum_q <= '0;
            ht_q  <= '0;
            v1_q  <= 1'b0;
            v2_q  <= 1'b0;
            v3_q  <= 1'b0;
        end else begin
            v1_q <= valid_i;
            v2_q <= v1_q;
            v3_q <= v2_q;
            if (valid_i) begin
                p1_q <= zt_i * ht1_i;
                p2_q <= omz * htb_i;
            end
            if (v1_q) begin
                sum_q <= sum_d;
            end
            if (v2_q) begin
                ht_q <= red_d;
            end
        end
    end

    assign ht_o    = ht_q;
    assign valid_o = v3_q;

endmodule : gru_update_dp

`default_nettype wire

// File: rtl/gru_update_seq.sv
//------------------------------------------------------------------------------
// gru_update_seq
// Sweeps HIDDEN_N elements: reads zt/ht1/htb from external buffers, pushes
// them through the gru_update_dp pipe and writes ht_out back in address order.
// Read-to-write latency is 4 cycles; a hold-free sweep is HIDDEN_N+5 cycles
// from start to done.
// Build option: GRU_UPDATE_SAT_EN (used inside gru_update_dp).
// Rev 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module gru_update_seq
    import gru_pkg::*;
#(
    parameter int DATABIT  = gru_pkg::DATABIT,
    parameter int FRAC     = gru_pkg::FRAC,
    parameter int HIDDEN_N = 32,
    parameter int ADDR_W   = $clog2(HIDDEN_N)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               hold,
    output logic               busy,
    output logic               done,
    output logic               rd_en,
    output logic [ADDR_W-1:0]  rd_addr,
    input  logic [DATABIT-1:0] zt_in,
    input  logic [DATABIT-1:0] ht1_in,
    input  logic [DATABIT-1:0] htb_in,
    output logic               wr_en,
    output logic [ADDR_W-1:0]  wr_addr,
    output logic [DATABIT-1:0] ht_out
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(HIDDEN_N - 1);

    gru_state_e        state_q, state_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic              rvld_q;
    logic              issue, last_wr;
    logic              dp_valid;
    logic [DATABIT-1:0] dp_ht;

    // Next state, address counters and issue strobe
    always_comb begin
        state_d   = state_q;
        rd_addr_d = rd_addr_q;
        wr_addr_d = wr_addr_q;
        issue     = (state_q == RUN) && !hold;
        last_wr   = dp_valid && (wr_addr_q == LAST_ADDR);

        // Write address advances with each result; it never wraps
        if (dp_valid && !last_wr) begin
            wr_addr_d = wr_addr_q + ADDR_W'(1);
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = RUN;
                    rd_addr_d = '0;
                    wr_addr_d = '0;
                end
            end
            RUN: begin
                if (issue) begin
                    if (rd_addr_q == LAST_ADDR) begin
                        state_d = DRAIN;
                    end else begin
                        rd_addr_d = rd_addr_q + ADDR_W'(1);
                    end
                end
            end
            DRAIN: begin
                if (last_wr) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, counters and the read-data-valid flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            rd_addr_q <= '0;
            wr_addr_q <= '0;
            rvld_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            rd_addr_q <= rd_addr_d;
            wr_addr_q <= wr_addr_d;
            rvld_q    <= issue;
        end
    end

    gru_update_dp #(
        .DATABIT (DATABIT),
        .FRAC    (FRAC)
    ) u_dp (
        .clk     (clk),
        .rst_n   (rst_n),
        .zt_i    (zt_in),
        .ht1_i   (ht1_in),
        .htb_i   (htb_in),
        .valid_i (rvld_q),
        .ht_o    (dp_ht),
        .valid_o (dp_valid)
    );

    assign busy    = (state_q != IDLE);
    assign done    = (state_q == DONE);
    assign rd_en   = issue;
    assign rd_addr = rd_addr_q;
    assign wr_en   = dp_valid;
    assign wr_addr = wr_addr_q;
    assign ht_out  = dp_ht;

endmodule : gru_update_seq

`default_nettype wire

// File: tb/tb_gru_update_seq.sv
//------------------------------------------------------------------------------
// tb_gru_update_seq
// Self-checking bench for gru_update_seq with an arithmetic reference model.
// Build option: GRU_UPDATE_SAT_EN selects the saturating reference.
// Rev 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_gru_update_seq;
    import gru_pkg::*;

    localparam int N  = 32;
    localparam int DW = 16;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst_n, start, hold;
    logic          busy, done, rd_en, wr_en;
    logic [AW-1:0] rd_addr, wr_addr;
    logic [DW-1:0] zt_in, ht1_in, htb_in, ht_out;

    logic [DW-1:0] zt_mem [N];
    logic [DW-1:0] ht1_mem[N];
    logic [DW-1:0] htb_mem[N];

    int            wq_addr[$];
    logic [DW-1:0] wq_data[$];

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    gru_update_seq #(
        .DATABIT  (DW),
        .FRAC     (14),
        .HIDDEN_N (N),
        .ADDR_W   (AW)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .hold    (hold),
        .busy    (busy),
        .done    (done),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .zt_in   (zt_in),
        .ht1_in  (ht1_in),
        .htb_in  (htb_in),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .ht_out  (ht_out)
    );

    // Buffer model: data appears one cycle after the read strobe
    always @(posedge clk) begin
        if (rd_en) begin
            zt_in  <= zt_mem[rd_addr];
            ht1_in <= ht1_mem[rd_addr];
            htb_in <= htb_mem[rd_addr];
        end
    end

    // Write monitor
    always @(negedge clk) begin
        if (wr_en) begin
            wq_addr.push_back(int'(wr_addr));
            wq_data.push_back(ht_out);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: real-valued-style arithmetic on integers, 18-bit sum, then reduce
    function automatic logic [DW-1:0] ref_ht(input logic [DW-1:0] z, input logic [DW-1:0] h1,
                                             input logic [DW-1:0] hb);
        longint zi, a, b, s;
        zi = longint'($signed(z));
        a  = (zi * longint'($signed(h1))) >>> 14;
        b  = ((longint'(ONE_Q) - zi) * longint'($signed(hb))) >>> 14;
        s  = (a + b) & 64'h3FFFF;
        if (s >= 64'h20000) s = s - 64'h40000;
`ifdef GRU_UPDATE_SAT_EN
        if (s > 32767)  s = 32767;
        if (s < -32768) s = -32768;
`endif
        return DW'(s);
    endfunction

    task automatic fill_const(input logic [DW-1:0] z, input logic [DW-1:0] h1, input logic [DW-1:0] hb);
        for (int i = 0; i < N; i++) begin
            zt_mem[i] = z; ht1_mem[i] = h1; htb_mem[i] = hb;
        end
    endtask

    function automatic logic [DW-1:0] rnd_val();
        logic [DW-1:0] corner[5];
        corner = '{16'h8000, 16'h7FFF, 16'h4000, 16'h0000, 16'hC000};
        if ($urandom_range(7) == 0) return corner[$urandom_range(4)];
        return DW'($urandom);
    endfunction

    task automatic fill_rand();
        for (int i = 0; i < N; i++) begin
            zt_mem[i] = rnd_val(); ht1_mem[i] = rnd_val(); htb_mem[i] = rnd_val();
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_busy"},    busy,    0);
        check({tag, "_done"},    done,    0);
        check({tag, "_rd_en"},   rd_en,   0);
        check({tag, "_rd_addr"}, rd_addr, 0);
        check({tag, "_wr_en"},   wr_en,   0);
        check({tag, "_wr_addr"}, wr_addr, 0);
        check({tag, "_ht_out"},  ht_out,  0);
    endtask

    // hold_mode: 0 none, 1 three cycles at element 10, 2 random
    // abort_at: cycle index at which reset is asserted (-1 = never)
    // exp_const: fixed expected result for every element (-1 = use model)
    task automatic run_sweep(input int hold_mode, input int abort_at, input bit poke_mid,
                             input int exp_const);
        int issued   = 0;
        int extra    = 0;
        int done_cyc = -1;
        int n_before;
        bit saw_done;
        logic [DW-1:0] exp_v;
        wq_addr.delete();
        wq_data.delete();
        @(negedge clk);
        start = 1'b1;
        for (int j = 1; j <= 400; j++) begin
            @(negedge clk);
            start = poke_mid && (j == 15);
            case (hold_mode)
                1:       hold = (j >= 11) && (j <= 13);
                2:       hold = ($urandom_range(3) == 0);
                default: hold = 1'b0;
            endcase
            #1;
            check("rd_en", rd_en, (issued < N) && !hold);
            if ((issued < N) && !hold) check("rd_addr", rd_addr, issued);
            if (issued < N) begin
                if (hold) extra++;
                else      issued++;
            end
            if (j == abort_at) begin
                n_before = wq_addr.size();
                rst_n = 1'b0;
                #1;
                check_idle_outputs("abort");
                repeat (3) @(negedge clk);
                rst_n = 1'b1;
                hold  = 1'b0;
                start = 1'b0;
                saw_done = 1'b0;
                repeat (50) begin
                    @(negedge clk);
                    #1;
                    if (done) saw_done = 1'b1;
                end
                check("abort_no_done", saw_done, 0);
                check("abort_no_wr", wq_addr.size(), n_before);
                return;
            end
            if (done) begin
                done_cyc = j;
                break;
            end
        end
        hold = 1'b0;
        check("done_cycles", done_cyc, N + 5 + extra);
        // start coincident with done must be ignored
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        #1;
        check("start_at_done_ignored", busy, 0);
        check("done_pulse_width", done, 0);
        check("wr_count", wq_addr.size(), N);
        for (int i = 0; i < N && i < wq_addr.size(); i++) begin
            exp_v = (exp_const >= 0) ? DW'(exp_const) : ref_ht(zt_mem[i], ht1_mem[i], htb_mem[i]);
            check("wr_addr_order", wq_addr[i], i);
            check("ht_out", wq_data[i], exp_v);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        hold  = 1'b0;
        zt_in = '0; ht1_in = '0; htb_in = '0;
        fill_const('0, '0, '0);
        repeat (3) @(negedge clk);
        #1;
        check_idle_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        fill_const(16'h4000, 16'h2000, 16'h1000);
        run_sweep(0, -1, 1'b1, 32'h2000);

        fill_const(16'h2000, 16'h4000, 16'h0000);
        run_sweep(1, -1, 1'b0, 32'h2000);

        fill_const(16'h7FFF, 16'h7FFF, 16'h8000);
`ifdef GRU_UPDATE_SAT_EN
        run_sweep(0, -1, 1'b0, 32'h7FFF);
`else
        run_sweep(0, -1, 1'b0, 32'h7FFA);
`endif

        fill_rand();
        run_sweep(0, 16, 1'b0, -1);

        fill_rand();
        run_sweep(0, -1, 1'b0, -1);

        for (int k = 0; k < 4; k++) begin
            fill_rand();
            run_sweep(2, -1, 1'b0, -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_gru_update_seq

`default_nettype wire
